fhe_op_sequencer: RTL and testbench

Command-queue sequencer driving the register-file streaming ports and functional-unit select of the FHE polynomial datapath. It buffers polynomial operations (ADD, MUL, NTT) in a small FIFO and issues them one at a time. For each operation it pulses the regfile start strobes and holds operands and fu_sel stable. It counts write-back beats until the last coefficient, then reports completion or an error.

---
 rtl/fhe_op_sequencer_if.sv | 62 ++++++
 rtl/fhe_op_sequencer.sv | 134 +++++++++++++
 tb/tb_fhe_op_sequencer.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fhe_op_sequencer_if.sv
// Shared poly/op encodings and the sequencer's command, regfile and write-back bundle.
package fhe_op_sequencer_pkg;
    typedef enum logic {POLY_A = 1'b0, POLY_B = 1'b1} poly_sel_e;
    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_MUL = 2'd1;
    localparam logic [1:0] OP_NTT = 2'd2;
    localparam logic [1:0] OP_ILL = 2'd3;
endpackage

interface fhe_op_sequencer_if #(
    parameter int NREG   = 8,
    parameter int QDEPTH = 4
);
    import fhe_op_sequencer_pkg::*;
    localparam int RW = $clog2(NREG);
    localparam int QW = $clog2(QDEPTH) + 1;

    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [RW-1:0] cmd_rs1;
    logic [RW-1:0] cmd_rs2;
    logic [RW-1:0] cmd_rd;
    poly_sel_e     cmd_rs1_poly;
    poly_sel_e     cmd_rs2_poly;
    poly_sel_e     cmd_rd_poly;
    logic          rf_ready;
    logic          rs1_start;
    logic          rs2_start;
    logic          rd_start;
    logic [RW-1:0] rs1_reg;
    logic [RW-1:0] rs2_reg;
    logic [RW-1:0] rd_reg;
    poly_sel_e     rs1_poly;
    poly_sel_e     rs2_poly;
    poly_sel_e     rd_poly;
    logic [1:0]    fu_sel;
    logic          wb_valid;
    logic          wb_last;
    logic          op_done;
    logic          op_err;
    logic          busy;
    logic [QW-1:0] q_count;

    modport master (
        output cmd_valid, cmd_op, cmd_rs1, cmd_rs2, cmd_rd,
        output cmd_rs1_poly, cmd_rs2_poly, cmd_rd_poly,
        output rf_ready, wb_valid, wb_last,
        input  cmd_ready, rs1_start, rs2_start, rd_start,
        input  rs1_reg, rs2_reg, rd_reg, rs1_poly, rs2_poly, rd_poly,
        input  fu_sel, op_done, op_err, busy, q_count
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_rs1, cmd_rs2, cmd_rd,
        input  cmd_rs1_poly, cmd_rs2_poly, cmd_rd_poly,
        input  rf_ready, wb_valid, wb_last,
        output cmd_ready, rs1_start, rs2_start, rd_start,
        output rs1_reg, rs2_reg, rd_reg, rs1_poly, rs2_poly, rd_poly,
        output fu_sel, op_done, op_err, busy, q_count
    );
endinterface

// File: rtl/fhe_op_sequencer.sv
// Command FIFO plus issue/run/done sequencer for the FHE polynomial datapath.
module fhe_op_sequencer
    import fhe_op_sequencer_pkg::*;
#(
    parameter int NREG    = 8,
    parameter int NCOEFF  = 4096,
    parameter int QDEPTH  = 4,
    parameter int TIMEOUT = 16384
) (
    input logic clk,
    input logic reset,
    fhe_op_sequencer_if.slave bus
);
    localparam int RW = $clog2(NREG);
    localparam int CW = $clog2(NCOEFF) + 1;
    localparam int PW = $clog2(QDEPTH);
    localparam int QW = PW + 1;
    localparam int TW = $clog2(TIMEOUT) + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    state;
    logic [1:0]    q_op  [QDEPTH];
    logic [RW-1:0] q_rs1 [QDEPTH];
    logic [RW-1:0] q_rs2 [QDEPTH];
    logic [RW-1:0] q_rd  [QDEPTH];
    poly_sel_e     q_p1  [QDEPTH];
    poly_sel_e     q_p2  [QDEPTH];
    poly_sel_e     q_pd  [QDEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [QW-1:0] count;
    logic [CW-1:0] beat_cnt;
    logic [TW-1:0] cyc_cnt;
    logic          err_q;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic          beats_ok;

    assign full     = (count == QW'(QDEPTH));
    assign empty    = (count == '0);
    assign push     = bus.cmd_valid && !full;
    assign pop      = (state == S_IDLE) && !empty && bus.rf_ready;
    assign beats_ok = (beat_cnt == CW'(NCOEFF));

    assign bus.cmd_ready = !full;
    assign bus.q_count   = count;
    assign bus.busy      = (state != S_IDLE) || !empty;
    assign bus.op_done   = (state == S_DONE) && beats_ok;
    assign bus.op_err    = err_q || ((state == S_DONE) && !beats_ok);

    always_ff @(posedge clk) begin
        if (push) begin
            q_op[wptr]  <= bus.cmd_op;
            q_rs1[wptr] <= bus.cmd_rs1;
            q_rs2[wptr] <= bus.cmd_rs2;
            q_rd[wptr]  <= bus.cmd_rd;
            q_p1[wptr]  <= bus.cmd_rs1_poly;
            q_p2[wptr]  <= bus.cmd_rs2_poly;
            q_pd[wptr]  <= bus.cmd_rd_poly;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= S_IDLE;
            wptr          <= '0;
            rptr          <= '0;
            count         <= '0;
            beat_cnt      <= '0;
            cyc_cnt       <= '0;
            err_q         <= 1'b0;
            bus.rs1_start <= 1'b0;
            bus.rs2_start <= 1'b0;
            bus.rd_start  <= 1'b0;
            bus.rs1_reg   <= '0;
            bus.rs2_reg   <= '0;
            bus.rd_reg    <= '0;
            bus.rs1_poly  <= POLY_A;
            bus.rs2_poly  <= POLY_A;
            bus.rd_poly   <= POLY_A;
            bus.fu_sel    <= OP_ADD;
        end else begin
            bus.rs1_start <= 1'b0;
            bus.rs2_start <= 1'b0;
            bus.rd_start  <= 1'b0;
            err_q         <= 1'b0;
            if (push) wptr <= wptr + PW'(1);
            if (pop) rptr <= rptr + PW'(1);
            count <= count + QW'(push) - QW'(pop);
            case (state)
                S_IDLE: begin
                    // Illegal heads are dropped here without touching the held operands
                    if (pop && q_op[rptr] == OP_ILL) begin
                        err_q <= 1'b1;
                    end else if (pop) begin
                        state         <= S_ISSUE;
                        bus.rs1_start <= 1'b1;
                        bus.rd_start  <= 1'b1;
                        bus.rs2_start <= (q_op[rptr] != OP_NTT);
                        bus.fu_sel    <= q_op[rptr];
                        bus.rs1_reg   <= q_rs1[rptr];
                        bus.rs2_reg   <= q_rs2[rptr];
                        bus.rd_reg    <= q_rd[rptr];
                        bus.rs1_poly  <= q_p1[rptr];
                        bus.rs2_poly  <= q_p2[rptr];
                        bus.rd_poly   <= q_pd[rptr];
                        beat_cnt      <= '0;
                        cyc_cnt       <= '0;
                    end
                end
                S_ISSUE: state <= S_RUN;
                S_RUN: begin
                    if (bus.wb_valid && beat_cnt != '1)
                        beat_cnt <= beat_cnt + CW'(1);
                    if (cyc_cnt != '1)
                        cyc_cnt <= cyc_cnt + TW'(1);
                    if (bus.wb_valid && bus.wb_last) begin
                        state <= S_DONE;
                    end else if (cyc_cnt == TW'(TIMEOUT - 1)) begin
                        state <= S_IDLE;
                        err_q <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fhe_op_sequencer.sv
// Randomized bench for fhe_op_sequencer against a queue-based command model.
module tb_fhe_op_sequencer;
    import fhe_op_sequencer_pkg::*;

    localparam int NREG    = 8;
    localparam int NCOEFF  = 128;
    localparam int QDEPTH  = 4;
    localparam int TIMEOUT = 600;

    typedef struct {
        logic [1:0] op;
        logic [2:0] rs1;
        logic [2:0] rs2;
        logic [2:0] rd;
        poly_sel_e  p1;
        poly_sel_e  p2;
        poly_sel_e  pd;
    } cmd_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    cmd_t model_q[$];
    cmd_t last;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    fhe_op_sequencer_if #(.NREG(NREG), .QDEPTH(QDEPTH)) bus ();

    fhe_op_sequencer #(
        .NREG(NREG), .NCOEFF(NCOEFF), .QDEPTH(QDEPTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic cmd_t mk(input logic [1:0] op,
                                input logic [2:0] r1, input poly_sel_e p1,
                                input logic [2:0] r2, input poly_sel_e p2,
                                input logic [2:0] rd, input poly_sel_e pd);
        cmd_t c;
        c.op = op; c.rs1 = r1; c.p1 = p1;
        c.rs2 = r2; c.p2 = p2; c.rd = rd; c.pd = pd;
        return c;
    endfunction

    function automatic cmd_t rand_cmd(input bit allow_ill);
        cmd_t c;
        c.op  = 2'($urandom_range(0, 2));
        if (allow_ill && $urandom_range(0, 5) == 0) c.op = 2'd3;
        c.rs1 = 3'($urandom);
        c.rs2 = 3'($urandom);
        c.rd  = 3'($urandom);
        c.p1  = poly_sel_e'($urandom_range(0, 1));
        c.p2  = poly_sel_e'($urandom_range(0, 1));
        c.pd  = poly_sel_e'($urandom_range(0, 1));
        return c;
    endfunction

    function automatic logic [31:0] strobes();
        return 32'({bus.rs1_start, bus.rs2_start, bus.rd_start});
    endfunction

    task automatic push(input cmd_t c);
        bus.cmd_valid    = 1'b1;
        bus.cmd_op       = c.op;
        bus.cmd_rs1      = c.rs1;
        bus.cmd_rs2      = c.rs2;
        bus.cmd_rd       = c.rd;
        bus.cmd_rs1_poly = c.p1;
        bus.cmd_rs2_poly = c.p2;
        bus.cmd_rd_poly  = c.pd;
        chk("cmd_ready", 32'(bus.cmd_ready), 32'(model_q.size() < QDEPTH));
        if (model_q.size() < QDEPTH) model_q.push_back(c);
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic expect_issue(output int t_issue, output int waited);
        cmd_t c;
        bit   s;
        bit   e;
        c = model_q.pop_front();
        s = 0; e = 0; waited = 0;
        while (!s && !e && waited < 64) begin
            tick();
            waited++;
            s = (strobes() != 0);
            e = bus.op_err;
        end
        t_issue = cyc;
        if (c.op == 2'd3) begin
            chk("ill_err", 32'(e), 32'd1);
            chk("ill_nostart", strobes(), 32'd0);
            chk("ill_hold_regs", 32'({bus.rs1_reg, bus.rs2_reg, bus.rd_reg}),
                32'({last.rs1, last.rs2, last.rd}));
            chk("ill_hold_fu", 32'(bus.fu_sel), 32'(last.op));
        end else begin
            chk("strobes", strobes(), 32'({1'b1, c.op != 2'd2, 1'b1}));
            chk("fu_sel", 32'(bus.fu_sel), 32'(c.op));
            chk("regs", 32'({bus.rs1_reg, bus.rs2_reg, bus.rd_reg}),
                32'({c.rs1, c.rs2, c.rd}));
            chk("polys", 32'({bus.rs1_poly, bus.rs2_poly, bus.rd_poly}),
                32'({c.p1, c.p2, c.pd}));
            chk("issue_no_err", 32'(bus.op_err), 32'd0);
            last = c;
        end
    endtask

    task automatic run_op(input int n, input bit with_last, input bit gaps,
                          input bit toggle_rf);
        bit bad = 0;
        bus.wb_valid = 1'($urandom);
        bus.wb_last  = 1'($urandom);
        for (int i = 1; i <= n; i++) begin
            tick();
            bad |= bus.op_done | bus.op_err | (strobes() != 0);
            while (gaps && $urandom_range(0, 3) == 0) begin
                bus.wb_valid = 1'b0;
                bus.wb_last  = 1'($urandom);
                tick();
                bad |= bus.op_done | bus.op_err | (strobes() != 0);
            end
            bus.wb_valid = 1'b1;
            bus.wb_last  = with_last && (i == n);
            if (toggle_rf) bus.rf_ready = (i == n) ? 1'b1 : 1'($urandom);
        end
        if (with_last) begin
            tick();
            bus.wb_valid = 1'b0;
            bus.wb_last  = 1'b0;
            chk("op_done", 32'(bus.op_done), 32'(n == NCOEFF));
            chk("op_err", 32'(bus.op_err), 32'(n != NCOEFF));
        end
        chk("quiet_run", 32'(bad), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_qcount"}, 32'(bus.q_count), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_ready"}, 32'(bus.cmd_ready), 32'd1);
        chk({tag, "_strobes"}, strobes(), 32'd0);
        chk({tag, "_done_err"}, 32'({bus.op_done, bus.op_err}), 32'd0);
        chk({tag, "_outs"}, 32'({bus.fu_sel, bus.rs1_reg, bus.rs2_reg, bus.rd_reg,
            bus.rs1_poly, bus.rs2_poly, bus.rd_poly}), 32'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t;
        int w;
        int prev;
        int k;
        int n;
        bit bad;
        bus.cmd_valid = 0; bus.cmd_op = 0;
        bus.cmd_rs1 = 0; bus.cmd_rs2 = 0; bus.cmd_rd = 0;
        bus.cmd_rs1_poly = POLY_A; bus.cmd_rs2_poly = POLY_A;
        bus.cmd_rd_poly = POLY_A;
        bus.rf_ready = 0; bus.wb_valid = 0; bus.wb_last = 0;
        last = mk(2'd0, 3'd0, POLY_A, 3'd0, POLY_A, 3'd0, POLY_A);
        repeat (2) tick();
        check_reset_outputs("rst");
        reset = 1'b1;
        tick();

        // ADD with full-length stream, latency from accept to strobes
        bus.rf_ready = 1'b1;
        push(mk(2'd0, 3'd0, POLY_A, 3'd1, POLY_B, 3'd2, POLY_A));
        expect_issue(t, w);
        chk("add_latency", 32'(w + 1), 32'd2);
        run_op(NCOEFF, 1, 0, 0);
        tick();
        chk("done_single", 32'({bus.op_done, bus.op_err}), 32'd0);
        chk("idle_busy", 32'(bus.busy), 32'd0);

        // NTT: no rs2 strobe
        push(mk(2'd2, 3'd3, POLY_B, 3'd0, POLY_A, 3'd4, POLY_A));
        expect_issue(t, w);
        chk("ntt_latency", 32'(w + 1), 32'd2);
        run_op(NCOEFF, 1, 1, 0);

        // Five pushes while regfile busy; issue in order with minimum spacing
        bus.rf_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(rand_cmd(0));
        chk("full_qcount", 32'(bus.q_count), 32'(QDEPTH));
        chk("full_ready", 32'(bus.cmd_ready), 32'd0);
        bus.rf_ready = 1'b1;
        prev = -1;
        while (model_q.size() > 0) begin
            expect_issue(t, w);
            if (prev >= 0) chk("spacing", 32'(t - prev), 32'(NCOEFF + 3));
            prev = t;
            run_op(NCOEFF, 1, 0, 0);
        end
        chk("drained_qcount", 32'(bus.q_count), 32'd0);

        // Illegal head followed by a MUL
        bus.rf_ready = 1'b0;
        push(mk(2'd3, 3'd7, POLY_B, 3'd7, POLY_B, 3'd7, POLY_B));
        push(mk(2'd1, 3'd5, POLY_B, 3'd6, POLY_A, 3'd7, POLY_B));
        bus.rf_ready = 1'b1;
        expect_issue(t, w);
        expect_issue(t, w);
        chk("after_ill_wait", 32'(w), 32'd1);
        run_op(NCOEFF, 1, 1, 0);

        // Early last beat
        push(rand_cmd(0));
        expect_issue(t, w);
        run_op(100, 1, 1, 0);

        // Timeout with no last beat
        push(rand_cmd(0));
        expect_issue(t, w);
        run_op(10, 0, 1, 0);
        tick();
        bus.wb_valid = 1'b0;
        bad = 0;
        while (!bus.op_err && cyc - t < TIMEOUT + 20) begin
            bad |= bus.op_done;
            tick();
        end
        chk("timeout_cycle", 32'(cyc - t), 32'(TIMEOUT + 1));
        chk("timeout_no_done", 32'({bad, bus.op_done}), 32'd0);
        chk("timeout_busy", 32'(bus.busy), 32'd0);
        tick();
        chk("timeout_err_pulse", 32'(bus.op_err), 32'd0);

        // Reset in the middle of a stream with one command queued
        push(rand_cmd(0));
        expect_issue(t, w);
        run_op(60, 0, 1, 0);
        push(rand_cmd(0));
        chk("pre_rst_qcount", 32'(bus.q_count), 32'd1);
        reset = 1'b0;
        tick();
        model_q.delete();
        last = mk(2'd0, 3'd0, POLY_A, 3'd0, POLY_A, 3'd0, POLY_A);
        check_reset_outputs("midrst");
        reset = 1'b1;
        bus.wb_valid = 1'b1;
        bus.wb_last = 1'b1;
        bad = 0;
        repeat (4) begin
            tick();
            bad |= bus.op_done | bus.op_err | bus.busy;
        end
        chk("post_rst_wb_ignored", 32'(bad), 32'd0);
        bus.wb_valid = 1'b0;
        bus.wb_last = 1'b0;

        // Randomized batches
        for (int r = 0; r < 5; r++) begin
            bus.rf_ready = 1'b0;
            k = $urandom_range(1, QDEPTH + 1);
            for (int i = 0; i < k; i++) push(rand_cmd(1));
            chk("rnd_qcount", 32'(bus.q_count), 32'(model_q.size()));
            bus.rf_ready = 1'b1;
            while (model_q.size() > 0) begin
                if (model_q[0].op == 2'd3) begin
                    expect_issue(t, w);
                end else begin
                    n = ($urandom_range(0, 2) == 0)
                        ? $urandom_range(1, NCOEFF + 8) : NCOEFF;
                    expect_issue(t, w);
                    run_op(n, 1, 1, 1);
                end
            end
        end
        repeat (3) tick();
        chk("end_busy", 32'(bus.busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
